// File: rtl/dmux_burst_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmux_pkg
// Description : Shared constants, FSM state type and round-robin pick helper
//               for the 1-to-4 demux burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Returns {hit, idx}. idx is the first ready channel at or after ptr,
    // wrapping modulo NUM_CH.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] ready,
                                               input logic [SEL_W-1:0]  ptr);
        logic [SEL_W:0]   w_res;
        logic [SEL_W-1:0] w_idx;
        w_res = '0;
        // Walk from the farthest offset down so the nearest ready channel wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = ptr + SEL_W'(i);
            if (ready[w_idx]) begin
                w_res = {1'b1, w_idx};
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmux_burst_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmux_rr_arbiter
// Description : Combinational round-robin channel picker. Thin wrapper around
//               rr_pick so the priority scan can be exercised on its own.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_rr_arbiter
    import dmux_pkg::*;
(
    input  logic [NUM_CH-1:0] ready,
    input  logic [SEL_W-1:0]  ptr,
    output logic              hit,
    output logic [SEL_W-1:0]  idx
);

    assign {hit, idx} = rr_pick(ready, ptr);

endmodule
`default_nettype wire

// File: rtl/dmux_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dmux_burst_scheduler
// Description : Round-robin burst scheduler for a 1-to-4 demux. Grants one
//               consumer lane at a time for BURST_LEN beats and passes the
//               producer stream through a one-entry registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_burst_scheduler
    import dmux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  sel,
    output logic              burst_done
);

    localparam int               CNT_W  = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(BURST_LEN - 1);

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_burst_done;

    logic                w_hit;
    logic [SEL_W-1:0]    w_idx;
    logic                w_sel_valid;
    logic                w_sel_ready;
    logic                w_in_ready;
    logic                w_in_hs;
    logic                w_out_hs;
    logic [NUM_CH-1:0]   w_sel_onehot;

    dmux_rr_arbiter u_arb (
        .ready (out_ready),
        .ptr   (r_ptr),
        .hit   (w_hit),
        .idx   (w_idx)
    );

    assign w_sel_valid  = r_out_valid[r_sel];
    assign w_sel_ready  = out_ready[r_sel];
    assign w_sel_onehot = NUM_CH'(1) << r_sel;
    // The output slot can take a new beat when empty or when it drains this cycle.
    assign w_in_ready   = (r_state == XFER) && (!w_sel_valid || w_sel_ready);
    assign w_in_hs      = in_valid && w_in_ready;
    assign w_out_hs     = w_sel_valid && w_sel_ready;

    // Scheduler FSM, beat counter and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= '0;
            r_out_data   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (w_hit) begin
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_in_hs) begin
                        // New beat overwrites the slot; valid stays set on a pass-through.
                        r_out_data  <= in_data;
                        r_out_valid <= w_sel_onehot;
                        r_cnt       <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= DRAIN;
                        end
                    end else if (w_out_hs) begin
                        r_out_valid <= '0;
                    end
                end
                DRAIN: begin
                    if (!w_sel_valid || w_sel_ready) begin
                        r_out_valid  <= '0;
                        r_burst_done <= 1'b1;
                        r_ptr        <= r_sel + 1'b1;
                        r_state      <= en ? ARB : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign sel        = r_sel;
    assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_dmux_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_burst_scheduler
// Description : Self-checking bench for dmux_burst_scheduler. Table-driven
//               round-robin run plus directed multi-cycle sequences, with a
//               beat scoreboard watching every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_burst_scheduler;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        out_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        sel;
    logic              burst_done;

    dmux_burst_scheduler #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sel        (sel),
        .burst_done (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Expected deliveries as {channel, data}.
    logic [9:0] sbq[$];

    typedef struct {
        logic       en;
        logic       iv;
        logic [7:0] id;
        logic [3:0] ordy;
        logic       x_ir;
        logic [3:0] x_ov;
        logic [7:0] x_od;
        logic [1:0] x_sel;
        logic       x_bd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic e, input logic iv, input logic [7:0] id,
                           input logic [3:0] ordy, input logic x_ir, input logic [3:0] x_ov,
                           input logic [7:0] x_od, input logic [1:0] x_sel, input logic x_bd);
        vec_t v;
        v.en = e; v.iv = iv; v.id = id; v.ordy = ordy;
        v.x_ir = x_ir; v.x_ov = x_ov; v.x_od = x_od; v.x_sel = x_sel; v.x_bd = x_bd;
        tbl.push_back(v);
    endtask

    // Drive one burst on the expected channel; returns once burst_done is seen.
    task automatic run_burst(input int ch, input logic [7:0] base, input int drop_en_at);
        int n;
        int budget;
        bit done;
        n = 0; budget = 0; done = 1'b0;
        while (!done && budget < 50) begin
            @(negedge clk);
            budget++;
            if (n < BURST_LEN) begin
                in_valid = 1'b1;
                in_data  = 8'(base + n);
            end else begin
                in_valid = 1'b0;
            end
            if (drop_en_at >= 0 && n >= drop_en_at) en = 1'b0;
            #1;
            if (n == BURST_LEN && burst_done) begin
                done = 1'b1;
            end else if (in_valid && in_ready) begin
                chk("grant_sel", 32'(sel), 32'(ch));
                sbq.push_back({2'(ch), in_data});
                n++;
            end
        end
        chk("burst_done_seen", 32'(done), 32'd1);
    endtask

    // Scoreboard: checks every output handshake just before the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                chk("onehot_valid", 32'($countones(out_valid) <= 1), 32'd1);
                for (int c = 0; c < 4; c++) begin
                    if (out_valid[c] && out_ready[c]) begin
                        logic [1:0] cc;
                        cc = 2'(c);
                        if (sbq.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL beat_unexpected: got ch%0d data %0h expected none", c, out_data);
                        end else begin
                            chk("beat", 32'({cc, out_data}), 32'(sbq.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Main stimulus.
    initial begin
        logic [7:0] d, prevd;
        logic [1:0] prevs;
        logic [3:0] ov;
        logic       rp[7];
        logic [7:0] dp[7];
        logic       irp[7];
        int         n, budget;

        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;

        // Round-robin run over all four lanes, every consumer ready.
        add_vec(1, 1, 8'h00, 4'hF, 0, 4'h0, 8'h00, 2'd0, 0);
        for (int b = 0; b < 4; b++) begin
            d     = 8'(4 * b);
            prevd = (b == 0) ? 8'h00 : 8'(4 * b - 1);
            prevs = (b == 0) ? 2'd0 : 2'(b - 1);
            ov    = 4'(1 << b);
            add_vec(1, 1, d, 4'hF, 0, 4'h0, prevd, prevs, (b != 0));
            for (int k = 0; k < 4; k++) begin
                add_vec(1, 1, 8'(d + k), 4'hF, 1, (k == 0) ? 4'h0 : ov,
                        (k == 0) ? prevd : 8'(d + k - 1), 2'(b), 0);
            end
            add_vec((b != 3), 1, 8'hEE, 4'hF, 0, ov, 8'(d + 3), 2'(b), 0);
        end
        add_vec(0, 0, 8'h00, 4'hF, 0, 4'h0, 8'h0F, 2'd3, 1);

        // 1: reset held with stimulus toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = i[0]; in_valid = ~i[0]; in_data = 8'(i * 37 + 5); out_ready = 4'(i * 5 + 3);
            #1;
            chk("reset_outputs", 32'({in_ready, out_valid, out_data, sel, burst_done}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;

        // 2: table-driven round robin.
        foreach (tbl[i]) begin
            @(negedge clk);
            en = tbl[i].en; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].x_ir && tbl[i].iv) sbq.push_back({tbl[i].x_sel, tbl[i].id});
            chk($sformatf("rr_row%0d", i),
                32'({in_ready, out_valid, out_data, sel, burst_done}),
                32'({tbl[i].x_ir, tbl[i].x_ov, tbl[i].x_od, tbl[i].x_sel, tbl[i].x_bd}));
        end

        // 3: skip non-ready lanes, then stall in arbitration with nobody ready.
        @(negedge clk);
        en = 1'b1; out_ready = 4'b0001;
        run_burst(0, 8'h20, -1);
        out_ready = 4'b0101;
        run_burst(2, 8'h30, -1);
        run_burst(0, 8'h38, -1);
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("arb_stall_in_ready", 32'(in_ready), 32'd0);
            chk("arb_stall_out_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 4'b1000;
        run_burst(3, 8'h3C, -1);

        // 4: backpressure on the granted lane mid-burst.
        out_ready = 4'b0001;
        rp  = '{1, 1, 0, 0, 1, 1, 1};
        dp  = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h42, 8'h43, 8'h99};
        irp = '{1, 1, 0, 0, 1, 1, 0};
        sbq.push_back({2'd0, 8'h40}); sbq.push_back({2'd0, 8'h41});
        sbq.push_back({2'd0, 8'h42}); sbq.push_back({2'd0, 8'h43});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ready = {3'b000, rp[i]}; in_valid = 1'b1; in_data = dp[i];
            #1;
            chk($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'(irp[i]));
            if (i == 0) chk("bp_sel", 32'(sel), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'b1111;
        #1;
        chk("bp_burst_done", 32'(burst_done), 32'd1);

        // 5: en dropped after beat 2 still completes the burst, then idles.
        run_burst(1, 8'h50, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("en_drop_idle_in_ready", 32'(in_ready), 32'd0);
            chk("en_drop_idle_valid", 32'(out_valid), 32'd0);
        end

        // 6: asynchronous reset in the middle of a burst.
        en = 1'b1;
        n = 0; budget = 0;
        while (n < 2 && budget < 20) begin
            @(negedge clk);
            budget++;
            in_valid = 1'b1; in_data = 8'(8'h60 + n);
            #1;
            if (in_ready) begin
                if (n == 0) begin
                    chk("rst_mid_sel", 32'(sel), 32'd2);
                    sbq.push_back({2'd2, 8'h60});
                end
                n++;
            end
        end
        chk("rst_mid_beats_taken", 32'(n), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({in_ready, out_valid, out_data, sel, burst_done}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_burst(0, 8'h70, -1);

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
